pcie_axi_lite_master_arbiter: RTL and testbench

2:1 AXI4-Lite master arbiter that shares the single M_AXI port produced by the PCIe AXI-Lite bridge with a second local master, such as a debug or config sequencer.
- Slave port S0 connects to the PCIe bridge master; slave port S1 connects to the local master; port M drives the downstream AXI-Lite interconnect.
- One transaction (read or write) is in flight at a time.
- Round-robin fairness between S0 and S1.
- All response fields pass through unmodified.

---
 rtl/pcie_axi_lite_master_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_pcie_axi_lite_master_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_axi_lite_master_arbiter
// Brief    : 2:1 round-robin AXI4-Lite master arbiter, one transaction in flight.
// Revision : 1.0
// ============================================================================
module pcie_axi_lite_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    // slave port 0 (PCIe bridge)
    input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
    input  logic                      s0_awvalid,
    output logic                      s0_awready,
    input  logic [DATA_WIDTH-1:0]     s0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
    input  logic                      s0_wvalid,
    output logic                      s0_wready,
    output logic [1:0]                s0_bresp,
    output logic                      s0_bvalid,
    input  logic                      s0_bready,
    input  logic [ADDR_WIDTH-1:0]     s0_araddr,
    input  logic                      s0_arvalid,
    output logic                      s0_arready,
    output logic [DATA_WIDTH-1:0]     s0_rdata,
    output logic [1:0]                s0_rresp,
    output logic                      s0_rvalid,
    input  logic                      s0_rready,
    // slave port 1 (local master)
    input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
    input  logic                      s1_awvalid,
    output logic                      s1_awready,
    input  logic [DATA_WIDTH-1:0]     s1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
    input  logic                      s1_wvalid,
    output logic                      s1_wready,
    output logic [1:0]                s1_bresp,
    output logic                      s1_bvalid,
    input  logic                      s1_bready,
    input  logic [ADDR_WIDTH-1:0]     s1_araddr,
    input  logic                      s1_arvalid,
    output logic                      s1_arready,
    output logic [DATA_WIDTH-1:0]     s1_rdata,
    output logic [1:0]                s1_rresp,
    output logic                      s1_rvalid,
    input  logic                      s1_rready,
    // downstream master port
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    // status
    output logic                      busy,
    output logic                      grant_id
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_ADDR = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_ADDR = 3'd3;
    localparam logic [2:0] c_RD_DATA = 3'd4;

    logic [2:0] r_state,    w_state_nxt;
    logic       r_rr_last,  w_rr_last_nxt;
    logic       r_grant_id, w_grant_nxt;
    logic       r_aw_done,  w_aw_done_nxt;
    logic       r_w_done,   w_w_done_nxt;

    logic w_wr_req0, w_wr_req1, w_req0, w_req1, w_pick, w_pick_wr;
    logic w_aw_hs, w_w_hs;

    assign w_wr_req0 = s0_awvalid & s0_wvalid;
    assign w_wr_req1 = s1_awvalid & s1_wvalid;
    assign w_req0    = w_wr_req0 | s0_arvalid;
    assign w_req1    = w_wr_req1 | s1_arvalid;
    // on a tie the port that did not win last time goes next
    assign w_pick    = (w_req0 & w_req1) ? ~r_rr_last : w_req1;
    assign w_pick_wr = w_pick ? w_wr_req1 : w_wr_req0;

    // upstream signals of the port currently owning the bus
    logic [ADDR_WIDTH-1:0]   w_g_awaddr, w_g_araddr;
    logic [DATA_WIDTH-1:0]   w_g_wdata;
    logic [DATA_WIDTH/8-1:0] w_g_wstrb;
    logic w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;

    assign w_g_awaddr  = r_grant_id ? s1_awaddr  : s0_awaddr;
    assign w_g_awvalid = r_grant_id ? s1_awvalid : s0_awvalid;
    assign w_g_wdata   = r_grant_id ? s1_wdata   : s0_wdata;
    assign w_g_wstrb   = r_grant_id ? s1_wstrb   : s0_wstrb;
    assign w_g_wvalid  = r_grant_id ? s1_wvalid  : s0_wvalid;
    assign w_g_bready  = r_grant_id ? s1_bready  : s0_bready;
    assign w_g_araddr  = r_grant_id ? s1_araddr  : s0_araddr;
    assign w_g_arvalid = r_grant_id ? s1_arvalid : s0_arvalid;
    assign w_g_rready  = r_grant_id ? s1_rready  : s0_rready;

    assign w_aw_hs = w_g_awvalid & ~r_aw_done & m_awready;
    assign w_w_hs  = w_g_wvalid  & ~r_w_done  & m_wready;

    // responses and readies destined for the granted port
    logic                  w_awready_g, w_wready_g, w_bvalid_g, w_arready_g, w_rvalid_g;
    logic [1:0]            w_bresp_g, w_rresp_g;
    logic [DATA_WIDTH-1:0] w_rdata_g;

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_last_nxt = r_rr_last;
        w_grant_nxt   = r_grant_id;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        m_awaddr      = '0;
        m_awvalid     = 1'b0;
        m_wdata       = '0;
        m_wstrb       = '0;
        m_wvalid      = 1'b0;
        m_bready      = 1'b0;
        m_araddr      = '0;
        m_arvalid     = 1'b0;
        m_rready      = 1'b0;
        w_awready_g   = 1'b0;
        w_wready_g    = 1'b0;
        w_bvalid_g    = 1'b0;
        w_bresp_g     = 2'b00;
        w_arready_g   = 1'b0;
        w_rvalid_g    = 1'b0;
        w_rdata_g     = '0;
        w_rresp_g     = 2'b00;

        case (r_state)
            c_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_grant_nxt   = w_pick;
                    w_rr_last_nxt = w_pick;
                    w_state_nxt   = w_pick_wr ? c_WR_ADDR : c_RD_ADDR;
                end
            end
            c_WR_ADDR: begin
                m_awaddr    = w_g_awaddr;
                m_wdata     = w_g_wdata;
                m_wstrb     = w_g_wstrb;
                m_awvalid   = w_g_awvalid & ~r_aw_done;
                m_wvalid    = w_g_wvalid & ~r_w_done;
                w_awready_g = m_awready & ~r_aw_done;
                w_wready_g  = m_wready & ~r_w_done;
                // AW and W complete independently; leave once both have
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_nxt   = c_WR_RESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_aw_done_nxt = r_aw_done | w_aw_hs;
                    w_w_done_nxt  = r_w_done | w_w_hs;
                end
            end
            c_WR_RESP: begin
                w_bvalid_g = m_bvalid;
                w_bresp_g  = m_bresp;
                m_bready   = w_g_bready;
                if (m_bvalid & w_g_bready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_RD_ADDR: begin
                m_araddr    = w_g_araddr;
                m_arvalid   = w_g_arvalid;
                w_arready_g = m_arready;
                if (w_g_arvalid & m_arready) begin
                    w_state_nxt = c_RD_DATA;
                end
            end
            c_RD_DATA: begin
                w_rvalid_g = m_rvalid;
                w_rdata_g  = m_rdata;
                w_rresp_g  = m_rresp;
                m_rready   = w_g_rready;
                if (m_rvalid & w_g_rready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_state    <= c_IDLE;
            r_rr_last  <= 1'b1;
            r_grant_id <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_grant_id <= w_grant_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
        end
    end

    // the port not holding the grant sees all-zero outputs
    assign s0_awready = ~r_grant_id & w_awready_g;
    assign s0_wready  = ~r_grant_id & w_wready_g;
    assign s0_bvalid  = ~r_grant_id & w_bvalid_g;
    assign s0_bresp   = r_grant_id ? 2'b00 : w_bresp_g;
    assign s0_arready = ~r_grant_id & w_arready_g;
    assign s0_rvalid  = ~r_grant_id & w_rvalid_g;
    assign s0_rdata   = r_grant_id ? '0 : w_rdata_g;
    assign s0_rresp   = r_grant_id ? 2'b00 : w_rresp_g;

    assign s1_awready = r_grant_id & w_awready_g;
    assign s1_wready  = r_grant_id & w_wready_g;
    assign s1_bvalid  = r_grant_id & w_bvalid_g;
    assign s1_bresp   = r_grant_id ? w_bresp_g : 2'b00;
    assign s1_arready = r_grant_id & w_arready_g;
    assign s1_rvalid  = r_grant_id & w_rvalid_g;
    assign s1_rdata   = r_grant_id ? w_rdata_g : '0;
    assign s1_rresp   = r_grant_id ? w_rresp_g : 2'b00;

    assign busy     = (r_state != c_IDLE);
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_pcie_axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_axi_lite_master_arbiter
// Brief    : Directed scenarios plus randomized traffic against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_pcie_axi_lite_master_arbiter;

    logic user_clk = 1'b0;
    logic user_reset = 1'b1;

    logic [1:0][31:0] s_awaddr, s_araddr, s_wdata;
    logic [1:0][3:0]  s_wstrb;
    logic [1:0]       s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    wire  [1:0]       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    wire  [1:0][1:0]  s_bresp, s_rresp;
    wire  [1:0][31:0] s_rdata;

    wire  [31:0] m_awaddr, m_araddr, m_wdata;
    wire  [3:0]  m_wstrb;
    wire         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    wire         busy, grant_id;

    pcie_axi_lite_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .user_clk(user_clk), .user_reset(user_reset),
        .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
        .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
        .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
        .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
        .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
        .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
        .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
        .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 user_clk = ~user_clk;

    wire [14:0] w_vr = {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
    wire w_mdata_any = |{m_awaddr, m_wdata, m_wstrb, m_araddr};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
    endtask

    task automatic do_reset();
        user_reset = 1'b1;
        clr();
        tick();
        tick();
        user_reset = 1'b0;
    endtask

    // random-phase state: upstream masters, downstream slave, reference model
    localparam int N_TXN = 25;
    bit          act[2], is_wr[2], aw_sent[2], w_sent[2], ar_sent[2];
    int          gap[2], left[2];
    logic [31:0] t_addr[2], t_data[2];
    logic [3:0]  t_strb[2];
    logic [31:0] ref_mem[4], slv_mem[4];
    bit          sl_aw, sl_w, sl_bpend, sl_bv, sl_rpend, sl_rv;
    int          sl_bdly, sl_rdly;
    logic [31:0] sl_awaddr, sl_wdata, sl_araddr, sl_rdata;
    logic [3:0]  sl_wstrb;
    logic [1:0]  sl_bresp, sl_rresp;
    bit          md_busy, md_owner, md_last;
    int          done_cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w_hs_n, aw_hs_n, wr_pulse_n;
        bit drop_aw, drop_w;

        // ---- reset state, then single S0 write ----
        do_reset();
        settle();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_vr", w_vr, 0);
        chk("rst_mdata", w_mdata_any, 0);

        s_awaddr[0] = 32'h1000_0004; s_wdata[0] = 32'hDEAD_BEEF; s_wstrb[0] = 4'hF;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        settle();
        chk("a_no_early_awvalid", {m_awvalid, m_wvalid, busy}, 0);
        tick();
        settle();
        chk("a_busy", busy, 1);
        chk("a_grant", grant_id, 0);
        chk("a_valids", {m_awvalid, m_wvalid}, 2'b11);
        chk("a_awaddr", m_awaddr, 32'h1000_0004);
        chk("a_wdata", {m_wdata, m_wstrb}, {32'hDEAD_BEEF, 4'hF});
        chk("a_readies", {s_awready, s_wready}, 4'b0101);
        tick();
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b00; s_bready[0] = 1'b1;
        settle();
        chk("a_bvalid", {s_bvalid, s_bresp[0], m_bready}, {2'b01, 2'b00, 1'b1});
        chk("a_aw_off", {m_awvalid, m_wvalid}, 0);
        tick();
        m_bvalid = 1'b0;
        settle();
        chk("a_idle", busy, 0);

        // ---- simultaneous reads: S0 first, then strict alternation ----
        do_reset();
        s_araddr[0] = 32'h0000_0A00; s_araddr[1] = 32'h0000_0B00;
        s_arvalid = 2'b11; s_rready = 2'b11; m_arready = 1'b1; m_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_rdata = 32'hA5A5_0000 + 32'(k);
            tick();
            settle();
            chk($sformatf("b_grant%0d", k), grant_id, k % 2);
            chk($sformatf("b_araddr%0d", k), m_araddr, (k % 2) ? 32'h0000_0B00 : 32'h0000_0A00);
            chk($sformatf("b_arready%0d", k), s_arready, (k % 2) ? 2'b10 : 2'b01);
            tick();
            settle();
            chk($sformatf("b_rvalid%0d", k), s_rvalid, (k % 2) ? 2'b10 : 2'b01);
            chk($sformatf("b_rdata%0d", k), s_rdata[k % 2], 32'hA5A5_0000 + 32'(k));
            tick();
            settle();
            chk($sformatf("b_idle%0d", k), busy, 0);
        end
        clr();

        // ---- slow S1 read (SLVERR); S0 write waits for IDLE ----
        s_araddr[1] = 32'h2000_0010; s_arvalid[1] = 1'b1; m_arready = 1'b1;
        tick();
        settle();
        chk("c_grant", grant_id, 1);
        chk("c_araddr", m_araddr, 32'h2000_0010);
        tick();
        s_arvalid[1] = 1'b0; s_rready[1] = 1'b1; m_arready = 1'b0;
        s_awaddr[0] = 32'h0000_0040; s_wdata[0] = 32'h0BAD_F00D; s_wstrb[0] = 4'h3;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            settle();
            chk("c_wait_quiet", {s_awready[0], s_wready[0], m_awvalid, m_wvalid, s_rvalid[1], busy}, 1);
            tick();
        end
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rresp = 2'd2;
        settle();
        chk("c_rvalid", s_rvalid, 2'b10);
        chk("c_rdata", s_rdata[1], 32'h1234_5678);
        chk("c_rresp", s_rresp[1], 2);
        tick();
        m_rvalid = 1'b0;
        settle();
        chk("c_idle", busy, 0);
        tick();
        settle();
        chk("c_wr_grant", {grant_id, m_awvalid, s_awready[0]}, 3'b011);
        chk("c_wr_addr", m_awaddr, 32'h0000_0040);
        tick();
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0; m_bvalid = 1'b1; s_bready[0] = 1'b1;
        settle();
        chk("c_bvalid", s_bvalid, 2'b01);
        tick();
        clr();

        // ---- S0 write+read together, W accepted 4 cycles before AW ----
        s_awaddr[0] = 32'h0000_0080; s_wdata[0] = 32'hCAFE_0001; s_wstrb[0] = 4'hF;
        s_araddr[0] = 32'h0000_00C0;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_arvalid[0] = 1'b1; m_wready = 1'b1;
        tick();
        w_hs_n = 0; aw_hs_n = 0; wr_pulse_n = 0;
        for (int i = 0; i < 5; i++) begin
            m_awready = (i == 4);
            settle();
            if (i == 0) chk("d_no_ar", m_arvalid, 0);
            w_hs_n     += int'(m_wvalid & m_wready);
            aw_hs_n    += int'(m_awvalid & m_awready);
            wr_pulse_n += int'(s_wready[0]);
            drop_w  = s_wvalid[0] & s_wready[0];
            drop_aw = s_awvalid[0] & s_awready[0];
            tick();
            if (drop_w)  s_wvalid[0] = 1'b0;
            if (drop_aw) s_awvalid[0] = 1'b0;
        end
        chk("d_w_hs", w_hs_n, 1);
        chk("d_aw_hs", aw_hs_n, 1);
        chk("d_wready_pulse", wr_pulse_n, 1);
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1; s_bready[0] = 1'b1;
        settle();
        chk("d_bvalid", s_bvalid, 2'b01);
        tick();
        m_bvalid = 1'b0; m_arready = 1'b1;
        tick();
        settle();
        chk("d_rd_grant", {busy, grant_id, m_arvalid}, 3'b101);
        chk("d_araddr", m_araddr, 32'h0000_00C0);
        tick();
        s_arvalid[0] = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h7777_0000; s_rready[0] = 1'b1;
        settle();
        chk("d_rvalid", {s_rvalid, s_rdata[0]}, {2'b01, 32'h7777_0000});
        tick();
        clr();

        // ---- reset while waiting in WR_RESP ----
        s_awaddr[1] = 32'h0000_0100; s_wdata[1] = 32'h5555_AAAA; s_wstrb[1] = 4'hF;
        s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        tick();
        tick();
        s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0; s_bready[1] = 1'b1;
        settle();
        chk("e_in_resp", {busy, grant_id}, 2'b11);
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        clr();
        settle();
        chk("e_rst_busy", {busy, grant_id}, 0);
        chk("e_rst_vr", w_vr, 0);
        s_araddr[1] = 32'h3000_0000; s_arvalid[1] = 1'b1; m_arready = 1'b1;
        tick();
        settle();
        chk("e_rd_grant", {busy, grant_id, m_arvalid}, 3'b111);
        tick();
        s_arvalid[1] = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0F0F_0F0F; s_rready[1] = 1'b1;
        settle();
        chk("e_rdata", s_rdata[1], 32'h0F0F_0F0F);
        tick();
        clr();
        settle();
        chk("e_idle", busy, 0);

        // ---- S0 AW without W is not a request; S1 read goes first ----
        s_awaddr[0] = 32'h0000_0200; s_wdata[0] = 32'h1111_2222; s_wstrb[0] = 4'h1;
        s_awvalid[0] = 1'b1; s_araddr[1] = 32'h0000_0300; s_arvalid[1] = 1'b1;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        tick();
        settle();
        chk("f_s1_first", {busy, grant_id, m_awvalid}, 3'b110);
        tick();
        s_arvalid[1] = 1'b0; m_rvalid = 1'b1; s_rready[1] = 1'b1;
        tick();
        m_rvalid = 1'b0;
        settle();
        chk("f_idle0", busy, 0);
        tick();
        settle();
        chk("f_idle1", busy, 0);
        tick();
        s_wvalid[0] = 1'b1;
        settle();
        chk("f_idle2", busy, 0);
        tick();
        settle();
        chk("f_wr_grant", {busy, grant_id, m_awvalid}, 3'b101);
        tick();
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0; m_bvalid = 1'b1; s_bready[0] = 1'b1;
        tick();
        clr();

        // ---- randomized traffic vs transaction-level model ----
        do_reset();
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; left[p] = N_TXN; gap[p] = 0;
            aw_sent[p] = 0; w_sent[p] = 0; ar_sent[p] = 0; is_wr[p] = 0;
            t_addr[p] = '0; t_data[p] = '0; t_strb[p] = '0;
        end
        for (int a = 0; a < 4; a++) begin
            ref_mem[a] = '0; slv_mem[a] = '0;
        end
        sl_aw = 0; sl_w = 0; sl_bpend = 0; sl_bv = 0; sl_rpend = 0; sl_rv = 0;
        sl_bdly = 0; sl_rdly = 0; sl_awaddr = '0; sl_wdata = '0; sl_wstrb = '0;
        sl_araddr = '0; sl_rdata = '0; sl_bresp = 2'b00; sl_rresp = 2'b00;
        md_busy = 0; md_owner = 0; md_last = 1; done_cnt = 0;

        for (int cyc = 0; cyc < 4000 && done_cnt < 2 * N_TXN; cyc++) begin
            bit req[2];
            bit o_resp;
            bit m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
            bit s_aw_hs[2], s_w_hs[2], s_b_hs[2], s_r_hs[2], s_ar_hs[2];
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && left[p] > 0) begin
                    if (gap[p] > 0) gap[p]--;
                    else begin
                        act[p] = 1; left[p]--;
                        is_wr[p] = 1'($urandom);
                        t_addr[p] = 32'(($urandom % 4) * 4);
                        t_data[p] = $urandom;
                        t_strb[p] = 4'($urandom);
                        aw_sent[p] = 0; w_sent[p] = 0; ar_sent[p] = 0;
                    end
                end
                s_awvalid[p] = act[p] & is_wr[p] & !aw_sent[p];
                s_wvalid[p]  = act[p] & is_wr[p] & !w_sent[p];
                s_arvalid[p] = act[p] & !is_wr[p] & !ar_sent[p];
                s_awaddr[p] = t_addr[p]; s_araddr[p] = t_addr[p];
                s_wdata[p] = t_data[p]; s_wstrb[p] = t_strb[p];
                s_bready[p] = ($urandom % 4) != 0;
                s_rready[p] = ($urandom % 4) != 0;
                req[p] = (s_awvalid[p] & s_wvalid[p]) | s_arvalid[p];
            end
            m_awready = 1'($urandom); m_wready = 1'($urandom); m_arready = 1'($urandom);
            m_bvalid = sl_bv; m_bresp = sl_bresp;
            m_rvalid = sl_rv; m_rdata = sl_rdata; m_rresp = sl_rresp;
            settle();

            chk("r_busy", busy, md_busy);
            if (md_busy) chk("r_grant", grant_id, md_owner);
            if (!md_busy) chk("r_m_idle", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
            for (int p = 0; p < 2; p++) begin
                if (!(md_busy && (md_owner == 1'(p))))
                    chk($sformatf("r_quiet%0d", p),
                        {s_awready[p], s_wready[p], s_bvalid[p], s_arready[p], s_rvalid[p],
                         s_rdata[p], s_bresp[p], s_rresp[p]}, 0);
            end
            if (m_awvalid) chk("r_awaddr", m_awaddr, t_addr[md_owner]);
            if (m_wvalid)  chk("r_wdata", {m_wdata, m_wstrb}, {t_data[md_owner], t_strb[md_owner]});
            if (m_arvalid) chk("r_araddr", m_araddr, t_addr[md_owner]);

            m_aw_hs = m_awvalid & m_awready; m_w_hs = m_wvalid & m_wready;
            m_b_hs = m_bvalid & m_bready; m_ar_hs = m_arvalid & m_arready;
            m_r_hs = m_rvalid & m_rready;
            for (int p = 0; p < 2; p++) begin
                s_aw_hs[p] = s_awvalid[p] & s_awready[p];
                s_w_hs[p]  = s_wvalid[p] & s_wready[p];
                s_ar_hs[p] = s_arvalid[p] & s_arready[p];
                s_b_hs[p]  = s_bvalid[p] & s_bready[p];
                s_r_hs[p]  = s_rvalid[p] & s_rready[p];
            end

            for (int p = 0; p < 2; p++) begin
                if (s_aw_hs[p]) aw_sent[p] = 1;
                if (s_w_hs[p])  w_sent[p] = 1;
                if (s_ar_hs[p]) ar_sent[p] = 1;
                if (s_b_hs[p]) begin
                    chk("r_b_port", p, md_owner);
                    chk("r_bresp", s_bresp[p], sl_bresp);
                    for (int b = 0; b < 4; b++)
                        if (t_strb[p][b]) ref_mem[t_addr[p][3:2]][8*b +: 8] = t_data[p][8*b +: 8];
                    act[p] = 0; done_cnt++;
                    gap[p] = (($urandom % 4) == 0) ? int'($urandom % 3) : 0;
                end
                if (s_r_hs[p]) begin
                    chk("r_r_port", p, md_owner);
                    chk("r_rdata", {s_rdata[p], s_rresp[p]}, {ref_mem[t_addr[p][3:2]], sl_rresp});
                    act[p] = 0; done_cnt++;
                    gap[p] = (($urandom % 4) == 0) ? int'($urandom % 3) : 0;
                end
            end

            if (m_b_hs) sl_bv = 0;
            if (m_r_hs) sl_rv = 0;
            if (m_aw_hs) begin sl_aw = 1; sl_awaddr = m_awaddr; end
            if (m_w_hs)  begin sl_w = 1; sl_wdata = m_wdata; sl_wstrb = m_wstrb; end
            if (sl_aw && sl_w) begin
                for (int b = 0; b < 4; b++)
                    if (sl_wstrb[b]) slv_mem[sl_awaddr[3:2]][8*b +: 8] = sl_wdata[8*b +: 8];
                sl_aw = 0; sl_w = 0; sl_bpend = 1; sl_bdly = int'($urandom % 4);
            end else if (sl_bpend) begin
                if (sl_bdly == 0) begin
                    sl_bpend = 0; sl_bv = 1; sl_bresp = 2'($urandom);
                end else sl_bdly--;
            end
            if (m_ar_hs) begin
                sl_araddr = m_araddr; sl_rpend = 1; sl_rdly = int'($urandom % 4);
            end else if (sl_rpend) begin
                if (sl_rdly == 0) begin
                    sl_rpend = 0; sl_rv = 1;
                    sl_rdata = slv_mem[sl_araddr[3:2]]; sl_rresp = 2'($urandom);
                end else sl_rdly--;
            end

            o_resp = s_b_hs[md_owner] | s_r_hs[md_owner];
            if (md_busy) begin
                if (o_resp) md_busy = 0;
            end else if (req[0] | req[1]) begin
                md_owner = (req[0] & req[1]) ? ~md_last : req[1];
                md_last = md_owner;
                md_busy = 1;
            end
            tick();
        end
        chk("r_all_done", done_cnt, 2 * N_TXN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
